apx_adder_pipe: RTL and testbench

- Next-generation approximate integer adder for the int_ops_apx library.
- Width is parametrised. Mode (exact / truncate / round) and the number of approximate bits (nab) are selected per transaction at run time; they are not fixed at elaboration.
- Two-stage pipeline with valid/ready handshakes on both sides.
- A built-in error monitor compares every approximate result against the exact sum and keeps running statistics, so accuracy characterisation runs in hardware instead of in a bench.

---
 rtl/apx_pkg.sv | 16 +
 rtl/apx_add_core.sv | 36 +++
 rtl/apx_adder_pipe.sv | 116 +++++++++++
 tb/tb_apx_adder_pipe.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apx_pkg.sv
// Shared definitions for the approximate adder: mode encodings and the
// low-bit mask builder used to select the approximated LSB field.
package apx_pkg;

  localparam logic [1:0] MODE_EXACT = 2'b00;
  localparam logic [1:0] MODE_TRUNC = 2'b01;
  localparam logic [1:0] MODE_RND   = 2'b10;

  localparam int unsigned MASK_MAX = 128;

  // Returns a mask with the low n bits set; callers narrow it to their width.
  function automatic logic [MASK_MAX-1:0] low_mask(input int unsigned n);
    low_mask = (MASK_MAX'(1) << n) - MASK_MAX'(1);
  endfunction

endpackage

// File: rtl/apx_add_core.sv
// Combinational approximate add: exact, truncated or rounded upper-field sum,
// plus the exact-minus-approximate error.
module apx_add_core
  import apx_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NAB_W = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic [NAB_W-1:0] n,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] c,
  output logic             cout,
  output logic [WIDTH:0]   err
);

  logic [WIDTH:0] exact;
  logic [WIDTH:0] upper;
  logic [WIDTH:0] approx;
  logic           cin;
  logic           approx_en;

  always_comb begin
    exact     = {1'b0, a} + {1'b0, b};
    approx_en = (mode == MODE_TRUNC) || (mode == MODE_RND);
    // mask ^ (mask >> 1) isolates bit n-1, and is zero when n == 0
    cin       = (mode == MODE_RND) && (|(a & b & (mask ^ (mask >> 1))));
    upper     = {1'b0, a >> n} + {1'b0, b >> n} + (WIDTH+1)'(cin);
    approx    = approx_en ? (upper << n) : exact;
    {cout, c} = approx;
    err       = exact - approx;
  end

endmodule

// File: rtl/apx_adder_pipe.sv
// Two-stage valid/ready approximate adder with an in-line error monitor
// that accumulates count, max error and error sum over consumed results.
module apx_adder_pipe
  import apx_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MAX_NAB = 16,
  parameter int unsigned NAB_W   = $clog2(MAX_NAB + 1),
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned SUM_W   = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  input  logic [NAB_W-1:0] in_nab,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic             out_cout,
  output logic [WIDTH:0]   out_err,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_count,
  output logic [WIDTH:0]   stat_max_err,
  output logic [SUM_W-1:0] stat_err_sum
);

  logic             adv;
  logic             consume;
  logic [NAB_W-1:0] nab_clamped;
  logic [WIDTH-1:0] mask_in;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [1:0]       s1_mode;
  logic [NAB_W-1:0] s1_n;
  logic [WIDTH-1:0] s1_mask;

  logic [WIDTH-1:0] core_c;
  logic             core_cout;
  logic [WIDTH:0]   core_err;
  logic [SUM_W:0]   sum_next;

  always_comb begin
    adv         = !out_valid || out_ready;
    in_ready    = rst || adv;
    consume     = out_valid && out_ready;
    nab_clamped = (in_nab > NAB_W'(MAX_NAB)) ? NAB_W'(MAX_NAB) : in_nab;
    mask_in     = WIDTH'(low_mask(32'(nab_clamped)));
    sum_next    = {1'b0, stat_err_sum} + (SUM_W+1)'(out_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= MODE_EXACT;
      s1_n     <= '0;
      s1_mask  <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_mode  <= in_mode;
      s1_n     <= nab_clamped;
      s1_mask  <= mask_in;
    end
  end

  apx_add_core #(
    .WIDTH (WIDTH),
    .NAB_W (NAB_W)
  ) u_core (
    .a    (s1_a),
    .b    (s1_b),
    .mode (s1_mode),
    .n    (s1_n),
    .mask (s1_mask),
    .c    (core_c),
    .cout (core_cout),
    .err  (core_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_c     <= '0;
      out_cout  <= 1'b0;
      out_err   <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      out_c     <= core_c;
      out_cout  <= core_cout;
      out_err   <= core_err;
    end
  end

  // Clear takes priority: a result consumed in the clear cycle is not counted.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_count   <= '0;
      stat_max_err <= '0;
      stat_err_sum <= '0;
    end else if (consume) begin
      if (stat_count != '1) stat_count <= stat_count + CNT_W'(1);
      if (out_err > stat_max_err) stat_max_err <= out_err;
      stat_err_sum <= sum_next[SUM_W] ? '1 : sum_next[SUM_W-1:0];
    end
  end

endmodule

// File: tb/tb_apx_adder_pipe.sv
// Scoreboard bench for apx_adder_pipe: driver pushes model results, monitor
// pops on every consumed output and tracks the expected statistics.
module tb_apx_adder_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [1:0]  in_mode = '0;
  logic [4:0]  in_nab = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_c;
  logic        out_cout;
  logic [32:0] out_err;
  logic        stat_clr = 1'b0;
  logic [31:0] stat_count;
  logic [32:0] stat_max_err;
  logic [47:0] stat_err_sum;

  apx_adder_pipe #(
    .WIDTH   (32),
    .MAX_NAB (16),
    .NAB_W   (5),
    .CNT_W   (32),
    .SUM_W   (48)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_mode      (in_mode),
    .in_nab       (in_nab),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_c        (out_c),
    .out_cout     (out_cout),
    .out_err      (out_err),
    .stat_clr     (stat_clr),
    .stat_count   (stat_count),
    .stat_max_err (stat_max_err),
    .stat_err_sum (stat_err_sum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] c;
    logic        cout;
    logic [32:0] err;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   npass = 0;
  bit   last_acc;

  longint unsigned m_count = 0;
  longint unsigned m_sum = 0;
  longint unsigned m_max = 0;

  task automatic chk(input string name, input logic [71:0] got, input logic [71:0] want);
    nchk++;
    if (got === want) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
  endtask

  // Plain-arithmetic reference: split operands by shifting, add the upper
  // fields, optionally round with the top dropped bits, shift back.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] m, input int unsigned nab);
    longint unsigned ea, eb, ex, ap, n;
    exp_t r;
    ea = a; eb = b;
    n  = (nab > 16) ? 16 : nab;
    ex = ea + eb;
    if (m == 2'd1 || m == 2'd2) begin
      ap = (ea >> n) + (eb >> n);
      if (m == 2'd2 && n > 0) ap += ((ea >> (n - 1)) & (eb >> (n - 1)) & 1);
      ap = ap << n;
    end else begin
      ap = ex;
    end
    r.c    = ap[31:0];
    r.cout = ap[32];
    r.err  = 33'(ex - ap);
    return r;
  endfunction

  task automatic cycle(input bit r, input bit v, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] m, input logic [4:0] nab, input bit ordy, input bit clr);
    @(negedge clk);
    rst = r; in_valid = v; in_a = a; in_b = b; in_mode = m; in_nab = nab;
    out_ready = ordy; stat_clr = clr;
    #1;
    last_acc = v && in_ready && !r;
    if (last_acc) sb.push_back(model(a, b, m, nab));
  endtask

  task automatic idle(input bit ordy);
    cycle(1'b0, 1'b0, '0, '0, 2'd0, 5'd0, ordy, 1'b0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || out_valid) && k < 50) begin
      idle(1'b1);
      k++;
    end
    if (k >= 50) chk("drain_timeout", 72'(sb.size()), 72'd0);
  endtask

  // Monitor: samples after the driver so it sees this cycle's out_ready/stat_clr.
  initial begin
    bit          hold;
    logic [65:0] held;
    exp_t        e;
    hold = 0;
    held = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        sb.delete();
        m_count = 0; m_sum = 0; m_max = 0;
        hold = 0;
      end else begin
        chk("stat_count", 72'(stat_count), 72'(m_count));
        chk("stat_max_err", 72'(stat_max_err), 72'(m_max));
        chk("stat_err_sum", 72'(stat_err_sum), 72'(m_sum));
        if (out_valid) begin
          if (hold) chk("hold_stable", 72'({out_c, out_cout, out_err}), 72'(held));
          if (out_ready) begin
            hold = 0;
            if (sb.size() == 0) begin
              nchk++;
              $display("FAIL stale_output: got c=%h with no pending result, expected none", out_c);
            end else begin
              e = sb.pop_front();
              chk("result", 72'({out_c, out_cout, out_err}), 72'({e.c, e.cout, e.err}));
              if (!stat_clr) begin
                m_count++;
                m_sum += e.err;
                if (e.err > m_max) m_max = e.err;
              end
            end
          end else begin
            hold = 1;
            held = {out_c, out_cout, out_err};
          end
        end else begin
          hold = 0;
        end
        if (stat_clr) begin
          m_count = 0; m_sum = 0; m_max = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_n;
    logic [1:0] m;
    cycle(1'b1, 1'b0, '0, '0, 2'd0, 5'd0, 1'b0, 1'b0);
    chk("in_ready_in_reset", 72'(in_ready), 72'd1);
    cycle(1'b1, 1'b0, '0, '0, 2'd0, 5'd0, 1'b0, 1'b0);
    idle(1'b1);
    chk("reset_out_valid", 72'(out_valid), 72'd0);
    chk("reset_in_ready", 72'(in_ready), 72'd1);
    chk("reset_stat_count", 72'(stat_count), 72'd0);

    // Wrap plus latency: visible exactly two cycles after acceptance.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1, 2'd0, 5'd0, 1'b1, 1'b0);
    chk("wrap_accept", 72'(last_acc), 72'd1);
    idle(1'b1);
    chk("latency_cycle1", 72'(out_valid), 72'd0);
    idle(1'b1);
    chk("latency_cycle2", 72'(out_valid), 72'd1);
    chk("wrap_c_cout_err", 72'({out_c, out_cout, out_err}), 72'({32'h0, 1'b1, 33'd0}));

    cycle(1'b0, 1'b1, 32'h0000_000F, 32'h0000_0008, 2'd1, 5'd4, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("trunc_c", 72'(out_c), 72'd0);
    chk("trunc_err", 72'(out_err), 72'd23);
    cycle(1'b0, 1'b1, 32'h0000_000F, 32'h0000_0008, 2'd2, 5'd4, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("round_c", 72'(out_c), 72'h10);
    chk("round_err", 72'(out_err), 72'd7);
    idle(1'b1);
    chk("stats_count3", 72'(stat_count), 72'd3);
    chk("stats_max23", 72'(stat_max_err), 72'd23);
    chk("stats_sum30", 72'(stat_err_sum), 72'd30);

    // Clear in the same cycle as a consume.
    cycle(1'b0, 1'b1, 32'h5, 32'h6, 2'd0, 5'd0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("clr_pending_valid", 72'(out_valid), 72'd1);
    cycle(1'b0, 1'b0, '0, '0, 2'd0, 5'd0, 1'b1, 1'b1);
    idle(1'b1);
    chk("clr_count", 72'(stat_count), 72'd0);
    chk("clr_max", 72'(stat_max_err), 72'd0);
    chk("clr_sum", 72'(stat_err_sum), 72'd0);

    // Backpressure: out_ready low for four cycles.
    cycle(1'b0, 1'b1, 32'h1111_1111, 32'h2222_2222, 2'd1, 5'd3, 1'b0, 1'b0);
    chk("bp_acc1", 72'(last_acc), 72'd1);
    cycle(1'b0, 1'b1, 32'h3333_3333, 32'h4444_4444, 2'd2, 5'd5, 1'b0, 1'b0);
    chk("bp_acc2", 72'(last_acc), 72'd1);
    cycle(1'b0, 1'b1, 32'h5555_5555, 32'h6666_6667, 2'd2, 5'd9, 1'b0, 1'b0);
    chk("bp_in_ready_low", 72'(in_ready), 72'd0);
    cycle(1'b0, 1'b1, 32'h5555_5555, 32'h6666_6667, 2'd2, 5'd9, 1'b0, 1'b0);
    chk("bp_still_blocked", 72'(last_acc), 72'd0);
    cycle(1'b0, 1'b1, 32'h5555_5555, 32'h6666_6667, 2'd2, 5'd9, 1'b1, 1'b0);
    chk("bp_acc3", 72'(last_acc), 72'd1);
    drain();

    for (int i = 0; i < 300; i++)
      cycle(1'b0, ($urandom % 4) != 0, $urandom, $urandom, 2'($urandom % 4),
            5'($urandom % 32), ($urandom % 4) != 0, ($urandom % 64) == 0);
    drain();

    acc_n = 0;
    for (int i = 0; i < 200 && acc_n < 100; i++) begin
      m = (($urandom % 2) != 0) ? 2'd2 : 2'd1;
      cycle(1'b0, 1'b1, $urandom, $urandom, m, 5'd0, 1'b1, 1'b0);
      if (last_acc) acc_n++;
    end
    chk("nab0_pairs", 72'(acc_n), 72'd100);
    for (int i = 0; i < 60; i++) begin
      m = (($urandom % 2) != 0) ? 2'd2 : 2'd1;
      cycle(1'b0, 1'b1, $urandom, $urandom, m, 5'd20, ($urandom % 3) != 0, 1'b0);
    end
    drain();

    // Reset with two results in flight.
    cycle(1'b0, 1'b1, $urandom, $urandom, 2'd1, 5'd7, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, $urandom, $urandom, 2'd2, 5'd7, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, '0, 2'd0, 5'd0, 1'b1, 1'b0);
    idle(1'b1);
    chk("midrst_out_valid", 72'(out_valid), 72'd0);
    chk("midrst_count", 72'(stat_count), 72'd0);
    chk("midrst_sum", 72'(stat_err_sum), 72'd0);
    for (int i = 0; i < 5; i++) idle(1'b1);
    drain();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
